// File: rtl/mem_bus_pkg.sv
// Shared address map, OAM DMA constants and the region decoder for mem_bus.
package mem_bus_pkg;

    localparam logic [15:0] ROM_LIMIT    = 16'h7FFF;
    localparam logic [15:0] UNMAP_BASE   = 16'h8000;
    localparam logic [15:0] UNMAP_LIMIT  = 16'hBFFF;
    localparam logic [15:0] WRAM_BASE    = 16'hC000;
    localparam logic [15:0] WRAM_LIMIT   = 16'hDFFF;
    localparam logic [15:0] ECHO_BASE    = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT   = 16'hFDFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_LIMIT    = 16'hFE9F;
    localparam logic [15:0] NOUSE_BASE   = 16'hFEA0;
    localparam logic [15:0] NOUSE_LIMIT  = 16'hFEFF;
    localparam logic [15:0] IO_BASE      = 16'hFF00;
    localparam logic [15:0] IO_LIMIT     = 16'hFF7F;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] IE_ADDR      = 16'hFFFF;

    localparam int OAM_LEN = 160;

    typedef enum logic {DMA_IDLE, DMA_ACTIVE} dma_state_t;

    typedef enum logic [3:0] {
        RG_ROM, RG_UNMAP, RG_WRAM, RG_OAM, RG_NOUSE, RG_DMA, RG_IO, RG_HRAM, RG_IE
    } region_t;

    function automatic region_t decode(input logic [15:0] a);
        if (a <= ROM_LIMIT)                                  return RG_ROM;
        if (a >= UNMAP_BASE && a <= UNMAP_LIMIT)             return RG_UNMAP;
        if ((a >= WRAM_BASE && a <= WRAM_LIMIT) ||
            (a >= ECHO_BASE && a <= ECHO_LIMIT))             return RG_WRAM;
        if (a >= OAM_BASE && a <= OAM_LIMIT)                 return RG_OAM;
        if (a >= NOUSE_BASE && a <= NOUSE_LIMIT)             return RG_NOUSE;
        if (a == DMA_REG_ADDR)                               return RG_DMA;
        if (a >= IO_BASE && a <= IO_LIMIT)                   return RG_IO;
        if (a >= HRAM_BASE && a <= HRAM_LIMIT)               return RG_HRAM;
        if (a == IE_ADDR)                                    return RG_IE;
        return RG_IO;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA sequencer: IDLE/ACTIVE FSM, byte index and per-byte sub-cycle counters,
// and the source address for the byte in flight. A new start restarts from byte 0.
module oam_dma
    import mem_bus_pkg::*;
#(
    parameter int DMA_T_PER_BYTE = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_start_hi,
    output logic        o_active,
    output logic        o_sub_first,
    output logic        o_oam_we,
    output logic [7:0]  o_oam_idx,
    output logic [15:0] o_src_addr
);
    localparam int SUB_W = (DMA_T_PER_BYTE > 1) ? $clog2(DMA_T_PER_BYTE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DMA_T_PER_BYTE - 1);
    localparam logic [7:0]       IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_t       state_q, state_d;
    logic [7:0]       idx_q, idx_d, src_hi_q, src_hi_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        src_hi_d = src_hi_q;
        if (state_q == DMA_ACTIVE) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = DMA_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
        if (i_start) begin
            state_d  = DMA_ACTIVE;
            idx_d    = '0;
            sub_d    = '0;
            src_hi_d = i_start_hi;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= DMA_IDLE;
            idx_q    <= '0;
            sub_q    <= '0;
            src_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sub_q    <= sub_d;
            src_hi_q <= src_hi_d;
        end
    end

    assign o_active    = (state_q == DMA_ACTIVE);
    assign o_sub_first = (sub_q == '0);
    assign o_oam_we    = o_active && (sub_q == SUB_LAST);
    assign o_oam_idx   = idx_q;
    assign o_src_addr  = {src_hi_q, idx_q};

endmodule

// File: rtl/mem_bus.sv
// CPU memory bus: decode, WRAM/OAM/HRAM/IE storage and registered read mux.
// OAM DMA transfers are built only when MEM_BUS_OAM_DMA_EN is defined.
module mem_bus
    import mem_bus_pkg::*;
#(
    parameter int WRAM_AW        = 13,
    parameter int DMA_T_PER_BYTE = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_mem_rd_addr,
    output logic [7:0]  o_mem_rd_data,
    input  logic        i_mem_wr_en,
    input  logic [15:0] i_mem_wr_addr,
    input  logic [7:0]  i_mem_wr_data,
    output logic [14:0] o_rom_addr,
    input  logic [7:0]  i_rom_data,
    output logic        o_dma_active
);
    logic [7:0] wram_q [2**WRAM_AW];
    logic [7:0] oam_q  [OAM_LEN];
    logic [7:0] hram_q [127];

    logic [7:0] rd_data_q, rd_data_d, dma_reg_q, dma_reg_d, ie_q, ie_d;
    logic [7:0] dma_byte_q, dma_byte_d, src_byte;

    logic        dma_active, dma_sub_first, dma_oam_we;
    logic [7:0]  dma_oam_idx;
    logic [15:0] dma_src_addr;

    region_t rd_rg, wr_rg;
    assign rd_rg = decode(i_mem_rd_addr);
    assign wr_rg = decode(i_mem_wr_addr);

`ifdef MEM_BUS_OAM_DMA_EN
    oam_dma #(.DMA_T_PER_BYTE(DMA_T_PER_BYTE)) u_oam_dma (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_mem_wr_en && (wr_rg == RG_DMA)),
        .i_start_hi  (i_mem_wr_data),
        .o_active    (dma_active),
        .o_sub_first (dma_sub_first),
        .o_oam_we    (dma_oam_we),
        .o_oam_idx   (dma_oam_idx),
        .o_src_addr  (dma_src_addr)
    );
`else
    assign dma_active    = 1'b0;
    assign dma_sub_first = 1'b0;
    assign dma_oam_we    = 1'b0;
    assign dma_oam_idx   = '0;
    assign dma_src_addr  = '0;
`endif

    assign o_rom_addr    = dma_active ? dma_src_addr[14:0] : i_mem_rd_addr[14:0];
    assign o_dma_active  = dma_active;
    assign o_mem_rd_data = rd_data_q;

    // Source pages E0-FF alias onto WRAM through the low address bits, same as C0-DF.
    always_comb begin
        src_byte = 8'hFF;
        if (!dma_src_addr[15])
            src_byte = i_rom_data;
        else if (dma_src_addr[15:14] == 2'b11)
            src_byte = wram_q[dma_src_addr[WRAM_AW-1:0]];
        dma_byte_d = (dma_active && dma_sub_first) ? src_byte : dma_byte_q;
    end

    always_comb begin
        case (rd_rg)
            RG_ROM:   rd_data_d = i_rom_data;
            RG_WRAM:  rd_data_d = wram_q[i_mem_rd_addr[WRAM_AW-1:0]];
            RG_OAM:   rd_data_d = oam_q[i_mem_rd_addr[7:0]];
            RG_NOUSE: rd_data_d = 8'h00;
            RG_DMA:   rd_data_d = dma_reg_q;
            RG_HRAM:  rd_data_d = hram_q[i_mem_rd_addr[6:0]];
            RG_IE:    rd_data_d = ie_q;
            default:  rd_data_d = 8'hFF;
        endcase
        if (dma_active && rd_rg != RG_HRAM)
            rd_data_d = 8'hFF;
    end

    logic       wr_ok, wram_we, hram_we, oam_we;
    logic [7:0] oam_waddr, oam_wdata;

    // While DMA owns the bus only HRAM and the DMA register stay writable.
    always_comb begin
        wr_ok     = i_mem_wr_en && i_rst_n &&
                    (!dma_active || wr_rg == RG_HRAM || wr_rg == RG_DMA);
        wram_we   = wr_ok && (wr_rg == RG_WRAM);
        hram_we   = wr_ok && (wr_rg == RG_HRAM);
        oam_we    = (dma_oam_we && i_rst_n) || (wr_ok && wr_rg == RG_OAM);
        oam_waddr = dma_oam_we ? dma_oam_idx : i_mem_wr_addr[7:0];
        oam_wdata = dma_oam_we ? (dma_sub_first ? src_byte : dma_byte_q) : i_mem_wr_data;
        dma_reg_d = (wr_ok && wr_rg == RG_DMA) ? i_mem_wr_data : dma_reg_q;
        ie_d      = (wr_ok && wr_rg == RG_IE)  ? i_mem_wr_data : ie_q;
    end

    always_ff @(posedge i_clk) begin
        if (wram_we) wram_q[i_mem_wr_addr[WRAM_AW-1:0]] <= i_mem_wr_data;
        if (hram_we) hram_q[i_mem_wr_addr[6:0]]         <= i_mem_wr_data;
        if (oam_we)  oam_q[oam_waddr]                   <= oam_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_data_q  <= 8'h00;
            dma_reg_q  <= 8'h00;
            ie_q       <= 8'h00;
            dma_byte_q <= 8'h00;
        end else begin
            rd_data_q  <= rd_data_d;
            dma_reg_q  <= dma_reg_d;
            ie_q       <= ie_d;
            dma_byte_q <= dma_byte_d;
        end
    end

endmodule

// File: tb/tb_mem_bus.sv
// Randomized bench for mem_bus against an address-map reference model.
// DMA scenarios are exercised when MEM_BUS_OAM_DMA_EN is defined.
module tb_mem_bus;
    localparam int T = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_mem_rd_addr = '0;
    logic [7:0]  o_mem_rd_data;
    logic        i_mem_wr_en = 1'b0;
    logic [15:0] i_mem_wr_addr = '0;
    logic [7:0]  i_mem_wr_data = '0;
    logic [14:0] o_rom_addr;
    logic [7:0]  i_rom_data;
    logic        o_dma_active;

    always #5 i_clk = ~i_clk;

    mem_bus #(.WRAM_AW(13), .DMA_T_PER_BYTE(T)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_mem_rd_addr(i_mem_rd_addr), .o_mem_rd_data(o_mem_rd_data),
        .i_mem_wr_en(i_mem_wr_en), .i_mem_wr_addr(i_mem_wr_addr), .i_mem_wr_data(i_mem_wr_data),
        .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_dma_active(o_dma_active)
    );

    function automatic logic [7:0] rom_fn(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction
    assign i_rom_data = rom_fn(o_rom_addr);

    // Reference model state
    logic [7:0] m_wram [8192];
    logic [7:0] m_oam  [160];
    logic [7:0] m_hram [127];
    logic [7:0] m_ie = 0, m_ff46 = 0, m_src = 0;
    bit         m_on = 0;
    int         m_cyc = 0;
    logic [7:0] exp_rd;
    bit         exp_act;
    int         n_tests = 0, n_fail = 0;

    function automatic logic [7:0] m_byte(input logic [15:0] a);
        if (a < 16'h8000) return rom_fn(a[14:0]);
        if (a < 16'hC000) return 8'hFF;
        if (a < 16'hFE00) return m_wram[a[12:0]];
        if (a < 16'hFEA0) return m_oam[int'(a) - 'hFE00];
        if (a < 16'hFF00) return 8'h00;
        if (a == 16'hFF46) return m_ff46;
        if (a < 16'hFF80) return 8'hFF;
        if (a < 16'hFFFF) return m_hram[int'(a) - 'hFF80];
        return m_ie;
    endfunction

    function automatic logic [7:0] m_dma_src(input logic [7:0] hi, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        if (hi < 8'h80) return rom_fn({hi[6:0], kk});
        if (hi < 8'hC0) return 8'hFF;
        return m_wram[{hi[4:0], kk}];
    endfunction

    function automatic bit is_hram(input logic [15:0] a);
        return a >= 16'hFF80 && a <= 16'hFFFE;
    endfunction

    // Random address that never lands on WRAM the bench has not initialised.
    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if (a >= 16'hC000 && a <= 16'hFDFF) a = 16'hC000 | (a & 16'h01FF);
        return a;
    endfunction

    // One clock: predict, then drive and advance the DUT.
    task automatic step(input logic [15:0] rd, input bit we, input logic [15:0] wa,
                        input logic [7:0] wd, input bit rst);
        bit was_on;
        was_on = m_on;
        if (!rst) exp_rd = 8'h00;
        else if (m_on && !is_hram(rd)) exp_rd = 8'hFF;
        else exp_rd = m_byte(rd);
        if (!rst) begin
            m_on = 0; m_cyc = 0; m_ff46 = 0; m_ie = 0;
        end else begin
            if (m_on) begin
                if ((m_cyc + 1) % T == 0) m_oam[m_cyc / T] = m_dma_src(m_src, m_cyc / T);
                m_cyc++;
                if (m_cyc == 160 * T) m_on = 0;
            end
            if (we && (!was_on || wa == 16'hFF46 || is_hram(wa))) begin
                if (wa >= 16'hC000 && wa <= 16'hFDFF) m_wram[wa[12:0]] = wd;
                else if (wa >= 16'hFE00 && wa <= 16'hFE9F) m_oam[int'(wa) - 'hFE00] = wd;
                else if (is_hram(wa)) m_hram[int'(wa) - 'hFF80] = wd;
                else if (wa == 16'hFFFF) m_ie = wd;
                else if (wa == 16'hFF46) begin
                    m_ff46 = wd;
`ifdef MEM_BUS_OAM_DMA_EN
                    m_on = 1; m_cyc = 0; m_src = wd;
`endif
                end
            end
        end
        exp_act = m_on;
        i_rst_n = rst; i_mem_rd_addr = rd;
        i_mem_wr_en = we; i_mem_wr_addr = wa; i_mem_wr_data = wd;
        @(posedge i_clk); #1;
        i_mem_wr_en = 1'b0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 127; i++) step(16'h0, 1, 16'hFF80 + 16'(i), 8'($urandom), 1);
        for (int i = 0; i < 160; i++) step(16'h0, 1, 16'hFE00 + 16'(i), 8'($urandom), 1);
        for (int i = 0; i < 512; i++) step(16'h0, 1, 16'hC000 + 16'(i), 8'($urandom), 1);
        for (int i = 0; i < 160; i++) step(16'h0, 1, 16'hD000 + 16'(i), 8'($urandom), 1);
        for (int i = 0; i < 160; i++) step(16'h0, 1, 16'hC800 + 16'(i), 8'($urandom), 1);
    endtask

    task automatic test_reset();
        step(16'hFF46, 0, 16'h0, 8'h0, 0);
        step(16'hC000, 0, 16'h0, 8'h0, 0);
        n_tests++;
        if (o_mem_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd got %h exp 00", o_mem_rd_data); end
        n_tests++;
        if (o_dma_active !== 1'b0) begin n_fail++; $display("FAIL reset_act got %b exp 0", o_dma_active); end
        step(16'hFF46, 0, 16'h0, 8'h0, 1);
        n_tests++;
        if (o_mem_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_ff46 got %h exp 00", o_mem_rd_data); end
        step(16'hFFFF, 0, 16'h0, 8'h0, 1);
        n_tests++;
        if (o_mem_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_ie got %h exp 00", o_mem_rd_data); end
    endtask

    task automatic test_wram_echo();
        step(16'h0, 1, 16'hC123, 8'h5A, 1);
        step(16'hC123, 0, 16'h0, 8'h0, 1);
        n_tests++;
        if (o_mem_rd_data !== 8'h5A) begin n_fail++; $display("FAIL wram_rd got %h exp 5a", o_mem_rd_data); end
        step(16'hE123, 0, 16'h0, 8'h0, 1);
        n_tests++;
        if (o_mem_rd_data !== 8'h5A) begin n_fail++; $display("FAIL echo_rd got %h exp 5a", o_mem_rd_data); end
    endtask

    task automatic test_hram_ie();
        logic [15:0] ra [5];
        logic [7:0]  rv [5];
        ra = '{16'hFF80, 16'hFFFE, 16'hFFFF, 16'hFEA5, 16'h9000};
        rv = '{8'h11, 8'h22, 8'h33, 8'h00, 8'hFF};
        step(16'h0, 1, 16'hFF80, 8'h11, 1);
        step(16'h0, 1, 16'hFFFE, 8'h22, 1);
        step(16'h0, 1, 16'hFFFF, 8'h33, 1);
        for (int i = 0; i < 5; i++) begin
            step(ra[i], 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== rv[i]) begin
                n_fail++; $display("FAIL map_rd %h got %h exp %h", ra[i], o_mem_rd_data, rv[i]);
            end
        end
    endtask

    task automatic test_same_addr();
        logic [15:0] a [2];
        a = '{16'hC010, 16'hFF90};
        for (int i = 0; i < 2; i++) begin
            step(16'h0, 1, a[i], 8'h3E, 1);
            step(a[i], 1, a[i], 8'hC7, 1);
            n_tests++;
            if (o_mem_rd_data !== 8'h3E) begin n_fail++; $display("FAIL same_old %h got %h exp 3e", a[i], o_mem_rd_data); end
            step(a[i], 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== 8'hC7) begin n_fail++; $display("FAIL same_new %h got %h exp c7", a[i], o_mem_rd_data); end
        end
    endtask

    task automatic test_rom();
        logic [15:0] a;
        for (int i = 0; i < 20; i++) begin
            a = (i == 0) ? 16'h0000 : (i == 1) ? 16'h7FFF : 16'($urandom_range(0, 16'h7FFF));
            step(a, 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== rom_fn(a[14:0]) || o_rom_addr !== a[14:0]) begin
                n_fail++; $display("FAIL rom %h got %h/%h exp %h/%h", a, o_mem_rd_data, o_rom_addr, rom_fn(a[14:0]), a[14:0]);
            end
        end
    endtask

    task automatic test_discard();
        logic [15:0] a [5];
        a = '{16'h0100, 16'h9000, 16'hFEA5, 16'hFF10, 16'hFF7F};
        for (int i = 0; i < 5; i++) step(16'h0, 1, a[i], 8'h99, 1);
        for (int i = 0; i < 5; i++) begin
            step(a[i], 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== exp_rd) begin n_fail++; $display("FAIL discard %h got %h exp %h", a[i], o_mem_rd_data, exp_rd); end
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, wa;
        for (int i = 0; i < 400; i++) begin
            rd = rnd_addr();
            wa = rnd_addr();
            if (wa == 16'hFF46) wa = 16'hFF47;
            step(rd, 1'($urandom), wa, 8'($urandom), 1);
            n_tests++;
            if (o_mem_rd_data !== exp_rd || o_dma_active !== exp_act) begin
                n_fail++; $display("FAIL random %h got %h/%b exp %h/%b", rd, o_mem_rd_data, o_dma_active, exp_rd, exp_act);
            end
        end
    endtask

`ifdef MEM_BUS_OAM_DMA_EN
    task automatic test_dma();
        int cnt;
        logic [15:0] rd;
        for (int k = 0; k < 160; k++) step(16'h0, 1, 16'hC000 + 16'(k), 8'(k) ^ 8'hA5, 1);
        step(16'h0, 1, 16'hFF80, 8'h77, 1);
        step(16'h0, 1, 16'hFF46, 8'hC0, 1);
        cnt = 0;
        for (int i = 0; i < 700; i++) begin
            rd = (i % 3 == 0) ? 16'hC000 : (i % 3 == 1) ? 16'hFF80 : rnd_addr();
            step(rd, (i % 7 == 0), rnd_addr(), 8'($urandom), 1);
            n_tests++;
            if (o_mem_rd_data !== exp_rd || o_dma_active !== exp_act) begin
                n_fail++; $display("FAIL dma_bus %0d %h got %h/%b exp %h/%b", i, rd, o_mem_rd_data, o_dma_active, exp_rd, exp_act);
            end
            if (o_dma_active) cnt++;
        end
        n_tests++;
        if (cnt !== 160 * T) begin n_fail++; $display("FAIL dma_len got %0d exp %0d", cnt, 160 * T); end
        for (int k = 0; k < 160; k++) begin
            step(16'hFE00 + 16'(k), 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== (8'(k) ^ 8'hA5)) begin
                n_fail++; $display("FAIL dma_oam %0d got %h exp %h", k, o_mem_rd_data, 8'(k) ^ 8'hA5);
            end
        end
    endtask

    task automatic test_dma_restart();
        int cnt;
        step(16'h0, 1, 16'hFF46, 8'hC0, 1);
        for (int i = 0; i < 100; i++) step(rnd_addr(), 0, 16'h0, 8'h0, 1);
        step(16'h0, 1, 16'hFF46, 8'hD0, 1);
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            step(rnd_addr(), 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_dma_active !== exp_act) begin n_fail++; $display("FAIL restart_act %0d got %b exp %b", i, o_dma_active, exp_act); end
            if (o_dma_active) cnt++;
            else break;
        end
        n_tests++;
        if (cnt !== 160 * T) begin n_fail++; $display("FAIL restart_len got %0d exp %0d", cnt, 160 * T); end
        for (int k = 0; k < 160; k++) begin
            step(16'hFE00 + 16'(k), 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== m_wram[16'h1000 + 16'(k)]) begin
                n_fail++; $display("FAIL restart_oam %0d got %h exp %h", k, o_mem_rd_data, m_wram[16'h1000 + 16'(k)]);
            end
        end
    endtask

    task automatic test_dma_reset();
        logic [7:0] snap [160];
        snap = m_oam;
        step(16'h0, 1, 16'hFF46, 8'hC8, 1);
        for (int i = 0; i < 50 * T + 2; i++) step(rnd_addr(), 0, 16'h0, 8'h0, 1);
        step(16'h0, 0, 16'h0, 8'h0, 0);
        n_tests++;
        if (o_dma_active !== 1'b0) begin n_fail++; $display("FAIL abort_act got %b exp 0", o_dma_active); end
        step(16'hFF46, 0, 16'h0, 8'h0, 1);
        n_tests++;
        if (o_mem_rd_data !== 8'h00) begin n_fail++; $display("FAIL abort_ff46 got %h exp 00", o_mem_rd_data); end
        for (int k = 0; k < 160; k++) begin
            step(16'hFE00 + 16'(k), 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== exp_rd || (k >= 50 && o_mem_rd_data !== snap[k])) begin
                n_fail++; $display("FAIL abort_oam %0d got %h exp %h", k, o_mem_rd_data, exp_rd);
            end
        end
    endtask
`else
    task automatic test_ff46_only();
        logic [7:0] snap [160];
        snap = m_oam;
        step(16'h0, 1, 16'hFF46, 8'hC0, 1);
        for (int i = 0; i < 50; i++) begin
            step(16'hFF46, 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== 8'hC0 || o_dma_active !== 1'b0) begin
                n_fail++; $display("FAIL ff46_only got %h/%b exp c0/0", o_mem_rd_data, o_dma_active);
            end
        end
        for (int k = 0; k < 160; k++) begin
            step(16'hFE00 + 16'(k), 0, 16'h0, 8'h0, 1);
            n_tests++;
            if (o_mem_rd_data !== snap[k]) begin n_fail++; $display("FAIL ff46_oam %0d got %h exp %h", k, o_mem_rd_data, snap[k]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        init_mem();
        test_wram_echo();
        test_hram_ie();
        test_same_addr();
        test_rom();
        test_discard();
        test_random();
`ifdef MEM_BUS_OAM_DMA_EN
        test_dma();
        test_dma_restart();
        test_dma_reset();
`else
        test_ff46_only();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus.md
MEM_BUS -- requirements
Module: mem_bus

Interface
REQ-001 Parameter WRAM_AW, default 13: WRAM address width (8 KiB).
REQ-002 Parameter DMA_T_PER_BYTE, default 4: clocks per OAM DMA byte (one M-cycle).
REQ-003 Port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port i_mem_rd_addr, input, 16: CPU read address.
REQ-006 Port o_mem_rd_data, output, 8: registered read data to CPU.
REQ-007 Port i_mem_wr_en, input, 1: CPU write strobe, one-clock pulse.
REQ-008 Port i_mem_wr_addr, input, 16: CPU write address.
REQ-009 Port i_mem_wr_data, input, 8: CPU write data.
REQ-010 Port o_rom_addr, output, 15: cartridge ROM address, combinational.
REQ-011 Port i_rom_data, input, 8: cartridge ROM data, combinational from o_rom_addr.
REQ-012 Port o_dma_active, output, 1: high while OAM DMA transfers.

Function
REQ-013 Read latency shall be one clock: o_mem_rd_data after edge N = contents at i_mem_rd_addr sampled at edge N.
REQ-014 Map: 0000-7FFF ROM; 8000-BFFF reads FF; C000-DFFF WRAM; E000-FDFF echo WRAM (addr[12:0]); FE00-FE9F OAM (160 B internal); FEA0-FEFF reads 00; FF46 DMA register; other FF00-FF7F read FF; FF80-FFFE HRAM (127 B); FFFF IE.
REQ-015 Writes to ROM, 8000-BFFF, FEA0-FEFF and unimplemented IO shall be discarded with no side effect.
REQ-016 Read and write in the same clock to the same address shall return the old data; write lands at that edge.
REQ-017 o_rom_addr = i_mem_rd_addr[14:0] when DMA idle; DMA source address[14:0] when DMA active.
REQ-018 CPU write to FF46 with value V shall store V (readable back) and start DMA from source V<<8.
REQ-019 DMA FSM states: IDLE, ACTIVE; IDLE->ACTIVE on edge after FF46 write; ACTIVE->IDLE after byte index 159 written.
REQ-020 In ACTIVE, byte k: sub-counter 0..DMA_T_PER_BYTE-1; source read at sub 0, OAM[k] written at last sub; then k+1, sub wraps to 0.
REQ-021 Source high byte E0-FF shall map to C0-DF (WRAM); 80-BF reads FF into OAM.
REQ-022 FF46 write during ACTIVE shall restart at k=0, sub=0 with the new source.
REQ-023 During ACTIVE, CPU reads outside FF80-FFFE return FF; CPU writes outside FF80-FFFE discarded except FF46.
REQ-024 o_dma_active high from first ACTIVE edge through the last-sub clock of byte 159; total 160*DMA_T_PER_BYTE clocks.

Reset
REQ-025 While i_rst_n low at an edge: o_mem_rd_data=00, DMA=IDLE, k=0, sub=0, o_dma_active=0, FF46=00, IE=00.
REQ-026 Reset mid-DMA shall abort with no further OAM writes; WRAM, HRAM, OAM contents are not cleared.

Configuration
REQ-027 Macro MEM_BUS_OAM_DMA_EN defined: REQ-017 to REQ-024 as written.
REQ-028 MEM_BUS_OAM_DMA_EN undefined: FF46 stored and readable only, no transfer, o_dma_active tied 0, o_rom_addr always i_mem_rd_addr[14:0].

Structure
REQ-029 Package mem_bus_pkg holds region base/limit constants, FF46/FFFF addresses, OAM_LEN=160, dma_state_t enum.
REQ-030 Sub-module oam_dma holds the DMA FSM, byte/sub counters and source address generation; mem_bus holds storage, decode and read mux.

Verification
REQ-031 Write C123<=5A, read C123 then E123 -> 5A on each, one clock after address.
REQ-032 Write FF80<=11, FFFE<=22, FFFF<=33; read back -> 11, 22, 33; read FEA5 -> 00, read 9000 -> FF.
REQ-033 Fill C000-C09F with k^A5, write FF46<=C0 -> o_dma_active high 640 clocks, then OAM FE00+k = k^A5; CPU read C000 during DMA -> FF, read FF80 -> HRAM data.
REQ-034 FF46<=C0, after 100 clocks FF46<=D0 -> transfer restarts; OAM ends with D000-D09F contents; active 640 clocks after 2nd write.
REQ-035 Reset asserted at byte 50 of DMA -> o_dma_active 0 next edge, OAM bytes 50-159 unchanged, FF46 reads 00.
REQ-036 With MEM_BUS_OAM_DMA_EN undefined, FF46<=C0 -> reads C0, o_dma_active stays 0, OAM unchanged.
